// File: rtl/rram_write_verify_ctrl.sv
// Program-and-verify sequencer for one RRAM cell: incremental-amplitude pulses, each followed by a verify read.
// Define RRAM_WV_ABORT_EN to add the abort input (status 4).
module rram_write_verify_ctrl #(
  parameter int DAC_W      = 6,
  parameter int ADC_W      = 8,
  parameter int PW_W       = 8,
  parameter int MAX_PULSES = 16,
  parameter int READ_CYC   = 4,
  parameter int ADC_TMO    = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [ADC_W-1:0] cmd_target,
  input  logic [DAC_W-1:0] cmd_amp,
  input  logic [PW_W-1:0]  cmd_pw,
`ifdef RRAM_WV_ABORT_EN
  input  logic             abort,
`endif
  output logic             drv_en,
  output logic             drv_pol,
  output logic [DAC_W-1:0] drv_amp,
  output logic             rd_en,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data,
  output logic             done,
  output logic [2:0]       status,
  output logic [7:0]       pulse_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE_READ, S_PULSE, S_GAP, S_READ, S_EVAL, S_DONE
  } state_t;

  localparam logic [15:0]      SETTLE_N  = 16'(READ_CYC);
  localparam logic [15:0]      TMO_LAST  = 16'(ADC_TMO - 1);
  localparam logic [7:0]       PULSE_MAX = 8'(MAX_PULSES);
  localparam logic [DAC_W-1:0] AMP_MAX   = '1;
  localparam logic [PW_W-1:0]  PW_ONE    = PW_W'(1);

  localparam logic [2:0] ST_OK    = 3'd0;
  localparam logic [2:0] ST_BUDGET = 3'd1;
  localparam logic [2:0] ST_SAT   = 3'd2;
  localparam logic [2:0] ST_TMO   = 3'd3;
`ifdef RRAM_WV_ABORT_EN
  localparam logic [2:0] ST_ABORT = 3'd4;
`endif

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic [ADC_W-1:0] target_q, target_d;
  logic [ADC_W-1:0] adc_q, adc_d;
  logic [DAC_W-1:0] amp_q, amp_d;
  logic [PW_W-1:0]  pw_q, pw_d;
  logic [PW_W-1:0]  pw_cnt_q, pw_cnt_d;
  logic [15:0]      settle_q, settle_d;
  logic [15:0]      tmo_q, tmo_d;
  logic             pre_q, pre_d;

  logic             cmd_ready_q, cmd_ready_d;
  logic             drv_en_q, drv_en_d;
  logic             drv_pol_q, drv_pol_d;
  logic [DAC_W-1:0] drv_amp_q, drv_amp_d;
  logic             rd_en_q, rd_en_d;
  logic             done_q, done_d;
  logic [2:0]       status_q, status_d;
  logic [7:0]       pulse_cnt_q, pulse_cnt_d;

  logic             met;

  assign met = op_q ? (adc_q >= target_q) : (adc_q <= target_q);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    target_d    = target_q;
    adc_d       = adc_q;
    amp_d       = amp_q;
    pw_d        = pw_q;
    pw_cnt_d    = pw_cnt_q;
    settle_d    = settle_q;
    tmo_d       = tmo_q;
    pre_d       = pre_q;
    status_d    = status_q;
    pulse_cnt_d = pulse_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d        = cmd_op;
          target_d    = cmd_target;
          amp_d       = cmd_amp;
          pw_d        = (cmd_pw == '0) ? PW_ONE : cmd_pw;
          pulse_cnt_d = 8'd0;
          status_d    = ST_OK;
          settle_d    = 16'd0;
          tmo_d       = 16'd0;
          pre_d       = 1'b1;
          state_d     = S_PRE_READ;
        end
      end
      S_PRE_READ, S_READ: begin
        // Samples arriving while the read bias settles are not trusted.
        if (settle_q < SETTLE_N) begin
          settle_d = settle_q + 16'd1;
        end else if (adc_valid) begin
          adc_d   = adc_data;
          state_d = S_EVAL;
        end else if (tmo_q >= TMO_LAST) begin
          status_d = ST_TMO;
          state_d  = S_DONE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_EVAL: begin
        if (met) begin
          status_d = ST_OK;
          state_d  = S_DONE;
        end else if (pulse_cnt_q == PULSE_MAX) begin
          status_d = (amp_q == AMP_MAX) ? ST_SAT : ST_BUDGET;
          state_d  = S_DONE;
        end else begin
          // The first pulse uses the commanded amplitude; later ones step up.
          if (!pre_q && amp_q != AMP_MAX) amp_d = amp_q + 1'b1;
          pulse_cnt_d = pulse_cnt_q + 8'd1;
          pw_cnt_d    = PW_ONE;
          state_d     = S_PULSE;
        end
      end
      S_PULSE: begin
        if (pw_cnt_q >= pw_q) state_d = S_GAP;
        else                  pw_cnt_d = pw_cnt_q + PW_ONE;
      end
      S_GAP: begin
        settle_d = 16'd0;
        tmo_d    = 16'd0;
        pre_d    = 1'b0;
        state_d  = S_READ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef RRAM_WV_ABORT_EN
    if (abort && state_q != S_IDLE && state_q != S_DONE) begin
      status_d    = ST_ABORT;
      pulse_cnt_d = pulse_cnt_q;
      state_d     = S_DONE;
    end
`endif

    // Outputs are decoded from the next state so they come straight off flops.
    cmd_ready_d = (state_d == S_IDLE);
    drv_en_d    = (state_d == S_PULSE);
    drv_pol_d   = drv_en_d & op_d;
    drv_amp_d   = drv_en_d ? amp_d : '0;
    rd_en_d     = (state_d == S_PRE_READ) || (state_d == S_READ);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 1'b0;
      target_q    <= '0;
      adc_q       <= '0;
      amp_q       <= '0;
      pw_q        <= PW_ONE;
      pw_cnt_q    <= '0;
      settle_q    <= 16'd0;
      tmo_q       <= 16'd0;
      pre_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      drv_en_q    <= 1'b0;
      drv_pol_q   <= 1'b0;
      drv_amp_q   <= '0;
      rd_en_q     <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= 3'd0;
      pulse_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      target_q    <= target_d;
      adc_q       <= adc_d;
      amp_q       <= amp_d;
      pw_q        <= pw_d;
      pw_cnt_q    <= pw_cnt_d;
      settle_q    <= settle_d;
      tmo_q       <= tmo_d;
      pre_q       <= pre_d;
      cmd_ready_q <= cmd_ready_d;
      drv_en_q    <= drv_en_d;
      drv_pol_q   <= drv_pol_d;
      drv_amp_q   <= drv_amp_d;
      rd_en_q     <= rd_en_d;
      done_q      <= done_d;
      status_q    <= status_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign drv_en    = drv_en_q;
  assign drv_pol   = drv_pol_q;
  assign drv_amp   = drv_amp_q;
  assign rd_en     = rd_en_q;
  assign done      = done_q;
  assign status    = status_q;
  assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_rram_write_verify_ctrl.sv
// Bench for rram_write_verify_ctrl: directed and random commands against a pulse-sequence reference model.
// Abort checks are compiled in when RRAM_WV_ABORT_EN is defined.
module tb_rram_write_verify_ctrl;
  localparam int DAC_W      = 6;
  localparam int ADC_W      = 8;
  localparam int PW_W       = 8;
  localparam int MAX_PULSES = 16;
  localparam int READ_CYC   = 4;
  localparam int ADC_TMO    = 255;
  localparam int AMP_TOP    = (1 << DAC_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_op = 1'b0;
  logic [ADC_W-1:0] cmd_target = '0;
  logic [DAC_W-1:0] cmd_amp = '0;
  logic [PW_W-1:0]  cmd_pw = '0;
`ifdef RRAM_WV_ABORT_EN
  logic             abort = 1'b0;
`endif
  logic             drv_en;
  logic             drv_pol;
  logic [DAC_W-1:0] drv_amp;
  logic             rd_en;
  logic             adc_valid = 1'b0;
  logic [ADC_W-1:0] adc_data = '0;
  logic             done;
  logic [2:0]       status;
  logic [7:0]       pulse_cnt;

  int total = 0;
  int bad = 0;
  int resp_q[$];
  int dly_q[$];

  always #5 clk = ~clk;

  rram_write_verify_ctrl #(
    .DAC_W(DAC_W), .ADC_W(ADC_W), .PW_W(PW_W), .MAX_PULSES(MAX_PULSES),
    .READ_CYC(READ_CYC), .ADC_TMO(ADC_TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_target(cmd_target), .cmd_amp(cmd_amp), .cmd_pw(cmd_pw),
`ifdef RRAM_WV_ABORT_EN
    .abort(abort),
`endif
    .drv_en(drv_en), .drv_pol(drv_pol), .drv_amp(drv_amp), .rd_en(rd_en),
    .adc_valid(adc_valid), .adc_data(adc_data),
    .done(done), .status(status), .pulse_cnt(pulse_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic op, input logic [7:0] tgt, input logic [5:0] amp0,
                           input logic [7:0] pw);
    for (int k = 0; k < 20 && cmd_ready !== 1'b1; k++) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_target = tgt; cmd_amp = amp0; cmd_pw = pw;
    @(negedge clk);
    // Scramble the command bus so anything not latched at accept shows up.
    cmd_valid = 1'b0; cmd_op = 1'($urandom); cmd_target = 8'($urandom);
    cmd_amp = 6'($urandom); cmd_pw = 8'($urandom);
  endtask

  // Runs one command; resp_q/dly_q give the ADC value (-1 = never answers) and
  // extra post-settle latency for each successive read window.
  task automatic run_cmd(input string name, input logic op, input logic [7:0] tgt,
                         input logic [5:0] amp0, input logic [7:0] pw);
    int exp_amps[$];
    int got_amps[$];
    int got_pol[$];
    int got_w[$];
    int exp_status, exp_cyc, exp_rd_last, pw_eff, amp, n, v, tgt_i;
    int cyc, rd_run, rd_last, ridx, cur_resp, cur_dly, done_cyc, done_status, done_pc;
    int overlap, idle_drive, nchk;
    bit seen_done, prev_drv, finished, met;

    tgt_i = int'(tgt);
    pw_eff = (pw == 8'd0) ? 1 : int'(pw);
    amp = int'(amp0); n = 0; exp_cyc = 0; exp_status = -1; exp_rd_last = 0;
    for (int i = 0; i < resp_q.size(); i++) begin
      v = resp_q[i];
      if (v < 0) begin
        exp_rd_last = READ_CYC + ADC_TMO;
        exp_cyc += READ_CYC + ADC_TMO + 1;
        exp_status = 3;
        break;
      end
      exp_rd_last = READ_CYC + 1 + dly_q[i];
      exp_cyc += READ_CYC + 1 + dly_q[i] + 1;
      met = op ? (v >= tgt_i) : (v <= tgt_i);
      if (met) begin exp_status = 0; exp_cyc += 1; break; end
      if (n == MAX_PULSES) begin
        exp_status = (amp == AMP_TOP) ? 2 : 1;
        exp_cyc += 1;
        break;
      end
      if (i > 0 && amp < AMP_TOP) amp++;
      exp_amps.push_back(amp);
      n++;
      exp_cyc += pw_eff + 1;
    end

    start_cmd(op, tgt, amp0, pw);

    rd_run = 0; rd_last = 0; ridx = 0; cur_resp = 0; cur_dly = 0;
    done_cyc = -1; done_status = -1; done_pc = -1;
    overlap = 0; idle_drive = 0; seen_done = 0; prev_drv = 0; finished = 0;
    for (cyc = 1; cyc <= 6000 && !finished; cyc++) begin
      if (seen_done) begin
        check({name, "/ready_after_done"}, 32'(cmd_ready), 32'd1);
        check({name, "/status_hold"}, 32'(status), exp_status);
        finished = 1;
      end else begin
        if (drv_en && rd_en) overlap++;
        if (!drv_en && (drv_amp != '0 || drv_pol)) idle_drive++;
        if (drv_en) begin
          if (!prev_drv) begin
            got_amps.push_back(int'(drv_amp));
            got_pol.push_back(int'(drv_pol));
            got_w.push_back(1);
          end else begin
            got_w[got_w.size()-1] += 1;
          end
        end
        prev_drv = drv_en;
        if (rd_en) begin
          rd_run++;
          if (rd_run == 1) begin
            cur_resp = (ridx < resp_q.size()) ? resp_q[ridx] : -1;
            cur_dly  = (ridx < dly_q.size()) ? dly_q[ridx] : 0;
            ridx++;
          end
          if (rd_run <= READ_CYC) begin
            adc_valid = 1'($urandom);
            adc_data  = op ? 8'hFF : 8'h00;
          end else if (cur_resp >= 0 && rd_run == READ_CYC + 1 + cur_dly) begin
            adc_valid = 1'b1;
            adc_data  = 8'(cur_resp);
          end else begin
            adc_valid = 1'b0;
            adc_data  = 8'($urandom);
          end
        end else begin
          if (rd_run > 0) rd_last = rd_run;
          rd_run = 0;
          adc_valid = 1'b0;
        end
        if (done) begin
          seen_done = 1; done_cyc = cyc; done_status = int'(status); done_pc = int'(pulse_cnt);
        end
        @(negedge clk);
      end
    end
    adc_valid = 1'b0;

    check({name, "/done_seen"}, 32'(seen_done), 32'd1);
    check({name, "/done_cycle"}, done_cyc, exp_cyc);
    check({name, "/status"}, done_status, exp_status);
    check({name, "/pulse_cnt"}, done_pc, exp_amps.size());
    check({name, "/pulses_seen"}, got_amps.size(), exp_amps.size());
    check({name, "/last_read_len"}, rd_last, exp_rd_last);
    check({name, "/drv_rd_overlap"}, overlap, 0);
    check({name, "/idle_drive"}, idle_drive, 0);
    nchk = (got_amps.size() < exp_amps.size()) ? got_amps.size() : exp_amps.size();
    for (int i = 0; i < nchk; i++) begin
      check($sformatf("%s/amp%0d", name, i), got_amps[i], exp_amps[i]);
      check($sformatf("%s/width%0d", name, i), got_w[i], pw_eff);
      check($sformatf("%s/pol%0d", name, i), got_pol[i], int'(op));
    end
    $display("cmd %s op=%0d tgt=%0d amp=%0d pw=%0d -> status=%0d pulses=%0d done@%0d",
             name, op, tgt, amp0, pw, done_status, done_pc, done_cyc);
  endtask

  task automatic set_resp(input int val, input int count);
    resp_q.delete(); dly_q.delete();
    for (int i = 0; i < count; i++) begin
      resp_q.push_back(val);
      dly_q.push_back(0);
    end
  endtask

  task automatic reset_mid_pulse();
    int rdc, pcyc;
    bit hit;
    start_cmd(1'b1, 8'h80, 6'd5, 8'd3);
    rdc = 0; pcyc = 0; hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      if (rd_en) begin
        rdc++;
        adc_valid = (rdc == READ_CYC + 1);
        adc_data  = 8'h00;
      end else begin
        adc_valid = 1'b0;
      end
      if (drv_en) pcyc++;
      if (pcyc == 2) begin
        rst_n = 1'b0;
        #1;
        check("rst/drv_en_async", 32'(drv_en), 32'd0);
        check("rst/drv_amp_async", 32'(drv_amp), 32'd0);
        check("rst/ready_async", 32'(cmd_ready), 32'd1);
        check("rst/pulse_cnt_async", 32'(pulse_cnt), 32'd0);
        hit = 1;
      end else begin
        @(negedge clk);
      end
    end
    check("rst/reached_pulse", 32'(hit), 32'd1);
    adc_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst/ready_after_release", 32'(cmd_ready), 32'd1);
    check("rst/rd_en_after_release", 32'(rd_en), 32'd0);
    $display("reset during pulse: drv_en=%0d cmd_ready=%0d", drv_en, cmd_ready);
  endtask

`ifdef RRAM_WV_ABORT_EN
  task automatic abort_in_read();
    int rdc;
    bit pulsed, hit;
    start_cmd(1'b1, 8'hFF, 6'd3, 8'd1);
    rdc = 0; pulsed = 0; hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      if (drv_en) pulsed = 1;
      if (rd_en) rdc++; else rdc = 0;
      adc_valid = rd_en && !pulsed && (rdc == READ_CYC + 1);
      adc_data  = 8'h00;
      if (pulsed && rd_en && rdc == 2) begin
        abort = 1'b1; hit = 1;
      end
      @(negedge clk);
    end
    abort = 1'b0; adc_valid = 1'b0;
    check("abort/reached_read", 32'(hit), 32'd1);
    check("abort/done", 32'(done), 32'd1);
    check("abort/status", 32'(status), 32'd4);
    check("abort/rd_en", 32'(rd_en), 32'd0);
    check("abort/pulse_cnt", 32'(pulse_cnt), 32'd1);
    @(negedge clk);
    check("abort/ready", 32'(cmd_ready), 32'd1);
    $display("abort in read: status=%0d pulse_cnt=%0d", status, pulse_cnt);
  endtask
`endif

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("reset/cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset/drv_en", 32'(drv_en), 32'd0);
    check("reset/drv_pol", 32'(drv_pol), 32'd0);
    check("reset/drv_amp", 32'(drv_amp), 32'd0);
    check("reset/rd_en", 32'(rd_en), 32'd0);
    check("reset/done", 32'(done), 32'd0);
    check("reset/status", 32'(status), 32'd0);
    check("reset/pulse_cnt", 32'(pulse_cnt), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    resp_q = '{8'h40, 8'h50, 8'h90}; dly_q = '{0, 0, 0};
    run_cmd("normal_set", 1'b1, 8'h80, 6'd10, 8'd3);

    resp_q = '{8'h10}; dly_q = '{0};
    run_cmd("preread_met", 1'b0, 8'h20, 6'd7, 8'd2);

    set_resp(0, MAX_PULSES + 1);
    run_cmd("saturation", 1'b1, 8'h80, 6'd60, 8'd2);

    set_resp(0, MAX_PULSES + 1);
    run_cmd("budget", 1'b1, 8'h80, 6'd0, 8'd0);

    set_resp(-1, 1);
    run_cmd("adc_timeout", 1'b1, 8'h80, 6'd4, 8'd1);

    reset_mid_pulse();

`ifdef RRAM_WV_ABORT_EN
    abort_in_read();
`endif

    for (int t = 0; t < 12; t++) begin
      logic       r_op;
      logic [7:0] r_tgt;
      r_op  = 1'($urandom);
      r_tgt = r_op ? 8'($urandom_range(192, 255)) : 8'($urandom_range(0, 63));
      resp_q.delete(); dly_q.delete();
      for (int i = 0; i <= MAX_PULSES; i++) begin
        resp_q.push_back($urandom_range(0, 255));
        dly_q.push_back($urandom_range(0, 3));
      end
      run_cmd($sformatf("rand%0d", t), r_op, r_tgt, 6'($urandom), 8'($urandom_range(0, 4)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
